card_dealer: RTL and testbench
==============================

// Module: card_dealer
// PURPOSE
//  Pseudo-random single-deck card source for the blackjack game controller.
//  Holds a 52-bit dealt mask and a free-running LFSR. On each accepted deal
//  request it returns one not-yet-dealt card (rank, suit, point value) with a
//  one-cycle valid pulse. Sits directly upstream of the game FSM, which issues
//  requests for player/dealer hits and for new rounds.
// PARAMETERS
//  LFSR_SEED   16'hACE1  non-zero LFSR reset value; fixes the deal order for sim
//  ACE_VALUE   4'd1      card_value reported for aces (game logic applies soft 11)
// PORTS
//  CLOCK_50    in   1  system clock; all state on rising edge
//  resetb      in   1  asynchronous active-low reset
//  new_deck    in   1  level-sampled; clears dealt mask, aborts any search
//  deal_req    in   1  request one card; accepted only when ready=1
//  ready       out  1  1 in IDLE with at least one card left
//  card_valid  out  1  one-cycle pulse; card_* fields valid in that cycle only
//  card_rank   out  4  1..13 (A,2..10,J,Q,K)
//  card_suit   out  2  0..3
//  card_value  out  4  ACE_VALUE for rank 1; 2..10 for ranks 2..10; 10 for ranks 11..13
//  cards_left  out  6  undealt cards, 52..0
//  deck_empty  out  1  cards_left==0
// BEHAVIOUR
//  Reset (async, resetb=0): mask=0, lfsr=LFSR_SEED, state=IDLE, ready=1,
//   card_valid=0, card_rank/suit/value=0, cards_left=52, deck_empty=0.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; steps every cycle in every state;
//   never 0. Start index = lfsr[5:0], minus 52 if >=52 (result 0..51).
//  Card index i in 0..51: suit=i/13, rank=(i%13)+1.
//  FSM IDLE -> SEARCH -> EMIT -> IDLE:
//   IDLE:   deal_req & ready -> latch start index into probe, go SEARCH.
//   SEARCH: one probe per cycle. mask[probe]==0 -> set mask bit, register card
//           fields, decrement cards_left, go EMIT. Else probe = (probe==51)?0:probe+1.
//   EMIT:   card_valid=1 for this cycle only; go IDLE.
//  Latency: deal_req at cycle N -> card_valid at N+2 (first probe hits) up to
//   N+53 (worst-case wrap). ready=0 in SEARCH and EMIT; deal_req then ignored
//   (not queued).
//  deck_empty/ready are combinational from cards_left and state.
//  deal_req while deck_empty: ignored, no card_valid, state stays IDLE.
//  new_deck=1 (any state): next edge mask=0, cards_left=52, state=IDLE,
//   card_valid=0; an in-flight search or EMIT is cancelled (no pulse).
//   new_deck has priority over a simultaneous deal_req. LFSR is not reseeded.
//  card_* fields hold their last value after the pulse; consumers use card_valid only.
//  SEARCH always terminates, since it is entered only with cards_left>0.
// STRUCTURE
//  blackjack_pkg: DECK_SIZE=52, RANKS=13, card_t {rank[3:0], suit[1:0]},
//   dealer_state_t enum {IDLE,SEARCH,EMIT}, function card_value(rank, ace).
//  Sub-module lfsr16 (CLOCK_50, resetb, SEED param, q[15:0]); all else inline.
// TESTING
//  1 reset: resetb low 3 cycles -> ready=1, card_valid=0, cards_left=52, deck_empty=0.
//  2 full deck: 52 deal_reqs (each after previous card_valid) -> 52 pulses, each
//    (rank,suit) exactly once, values match table, cards_left ends 0, deck_empty=1;
//    53rd req -> no card_valid within 60 cycles.
//  3 wrap: deal 51 cards, 52nd req -> last card found, latency <=53 cycles,
//    matches bit-accurate model with LFSR_SEED=16'hACE1.
//  4 abort: new_deck asserted 1 cycle into SEARCH -> no card_valid, cards_left=52,
//    ready=1 next cycle; new_deck+deal_req same cycle -> deck cleared, no deal.
//  5 busy: deal_req held high continuously -> exactly one pulse per IDLE entry,
//    spacing >=3 cycles, no dropped mask bits.
//  6 async reset mid-SEARCH: resetb low between edges -> outputs return to reset
//    values before the next clock edge.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared types and helpers for the blackjack card source.
// Card index i maps to suit i/13 and rank (i%13)+1.
package blackjack_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;
    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        EMIT
    } dealer_state_t;

    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t      c;
        logic [3:0] r;
        if (idx < 6'(RANKS)) begin
            c.suit = 2'd0;
            r      = idx[3:0];
        end else if (idx < 6'(2 * RANKS)) begin
            c.suit = 2'd1;
            r      = 4'(idx - 6'(RANKS));
        end else if (idx < 6'(3 * RANKS)) begin
            c.suit = 2'd2;
            r      = 4'(idx - 6'(2 * RANKS));
        end else begin
            c.suit = 2'd3;
            r      = 4'(idx - 6'(3 * RANKS));
        end
        c.rank = r + 4'd1;
        return c;
    endfunction

    function automatic logic [3:0] card_value(input logic [3:0] rank,
                                              input logic [3:0] ace);
        if (rank == 4'd1) begin
            return ace;
        end else if (rank > 4'd10) begin
            return 4'd10;
        end
        return rank;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// A non-zero seed keeps it off the all-zero lock-up state.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        resetb,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            q <= SEED;
        end else begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Single-deck card source: random start probe, linear search
// over the dealt mask, one-cycle valid pulse per card.
module card_dealer
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  ACE_VALUE = 4'd1
) (
    input  logic       CLOCK_50,
    input  logic       resetb,
    input  logic       new_deck,
    input  logic       deal_req,
    output logic       ready,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [3:0] card_value,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    dealer_state_t        state_q, state_d;
    logic [DECK_SIZE-1:0] mask_q, mask_d;
    logic [5:0]           probe_q, probe_d;
    logic [5:0]           left_q, left_d;
    card_t                card_q, card_d;
    logic [3:0]           val_q, val_d;
    logic [15:0]          lfsr;
    logic [5:0]           start;
    logic                 unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .CLOCK_50(CLOCK_50),
        .resetb  (resetb),
        .q       (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:6];
    assign start = (lfsr[5:0] >= 6'(DECK_SIZE)) ? lfsr[5:0] - 6'(DECK_SIZE)
                                                : lfsr[5:0];

    assign ready      = (state_q == IDLE) && (left_q != '0);
    assign deck_empty = (left_q == '0);
    // A clear arriving during EMIT suppresses the pulse as well.
    assign card_valid = (state_q == EMIT) && !new_deck;
    assign card_rank  = card_q.rank;
    assign card_suit  = card_q.suit;
    assign card_value = val_q;
    assign cards_left = left_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        probe_d = probe_q;
        left_d  = left_q;
        card_d  = card_q;
        val_d   = val_q;
        if (new_deck) begin
            mask_d  = '0;
            left_d  = 6'(DECK_SIZE);
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (deal_req && ready) begin
                        probe_d = start;
                        state_d = SEARCH;
                    end
                end
                SEARCH: begin
                    if (!mask_q[probe_q]) begin
                        mask_d[probe_q] = 1'b1;
                        card_d  = idx_to_card(probe_q);
                        val_d   = blackjack_pkg::card_value(card_d.rank, ACE_VALUE);
                        left_d  = left_q - 6'd1;
                        state_d = EMIT;
                    end else begin
                        probe_d = (probe_q == LAST_IDX) ? '0 : probe_q + 6'd1;
                    end
                end
                EMIT: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            mask_q  <= '0;
            probe_q <= '0;
            left_q  <= 6'(DECK_SIZE);
            card_q  <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            probe_q <= probe_d;
            left_q  <= left_d;
            card_q  <= card_d;
            val_q   <= val_d;
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Randomised and directed bench for card_dealer against a
// behavioural deck model.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       new_deck = 1'b0;
    logic       deal_req = 1'b0;
    logic       ready, card_valid, deck_empty;
    logic [3:0] card_rank, card_value;
    logic [1:0] card_suit;
    logic [5:0] cards_left;

    always #5 clk = ~clk;

    card_dealer #(.LFSR_SEED(16'hACE1), .ACE_VALUE(4'd1)) dut (
        .CLOCK_50  (clk),
        .resetb    (resetb),
        .new_deck  (new_deck),
        .deal_req  (deal_req),
        .ready     (ready),
        .card_valid(card_valid),
        .card_rank (card_rank),
        .card_suit (card_suit),
        .card_value(card_value),
        .cards_left(cards_left),
        .deck_empty(deck_empty)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction
    function automatic int rank_of(input int i); return i % 13 + 1; endfunction
    function automatic int suit_of(input int i); return i / 13; endfunction
    function automatic int value_of(input int r);
        return (r == 1) ? 1 : ((r > 10) ? 10 : r);
    endfunction

    // Model: a search of p probes yields a pulse p+1 cycles after acceptance.
    logic [15:0] m_lfsr = 16'hACE1;
    bit          m_dealt [52];
    int          m_left = 52, m_wait = 0, m_pend = 0;
    bit          m_emit = 1'b0;
    int          m_rank = 0, m_suit = 0, m_val = 0;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_lfsr = 16'hACE1;
            foreach (m_dealt[k]) m_dealt[k] = 1'b0;
            m_left = 52; m_wait = 0; m_emit = 1'b0;
            m_rank = 0; m_suit = 0; m_val = 0;
        end else begin
            if (new_deck) begin
                foreach (m_dealt[k]) m_dealt[k] = 1'b0;
                m_left = 52; m_wait = 0; m_emit = 1'b0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_dealt[m_pend] = 1'b1;
                    m_left--;
                    m_rank = rank_of(m_pend);
                    m_suit = suit_of(m_pend);
                    m_val  = value_of(m_rank);
                    m_emit = 1'b1;
                end
            end else if (m_emit) begin
                m_emit = 1'b0;
            end else if (deal_req && m_left > 0) begin
                int s;
                s = int'(m_lfsr[5:0]);
                if (s >= 52) s -= 52;
                for (int k = 0; k < 52; k++) begin
                    if (!m_dealt[(s + k) % 52]) begin
                        m_pend = (s + k) % 52;
                        m_wait = k + 1;
                        break;
                    end
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    bit chk_en = 1'b0;
    int cyc_n = 0;
    int last_pulse = -1000;
    int min_sp = 1000;
    int got[$];

    always @(negedge clk) begin
        cyc_n++;
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(m_wait == 0 && !m_emit && m_left > 0));
            chk("card_valid", 32'(card_valid), 32'(m_emit && !new_deck));
            chk("cards_left", 32'(cards_left), m_left);
            chk("deck_empty", 32'(deck_empty), 32'(m_left == 0));
            chk("card_rank", 32'(card_rank), m_rank);
            chk("card_suit", 32'(card_suit), m_suit);
            chk("card_value", 32'(card_value), m_val);
        end
        if (card_valid === 1'b1) begin
            got.push_back(int'(card_suit) * 13 + int'(card_rank) - 1);
            if (cyc_n - last_pulse < min_sp) min_sp = cyc_n - last_pulse;
            last_pulse = cyc_n;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic deal_one(output int lat);
        deal_req = 1'b1;
        cyc();
        deal_req = 1'b0;
        lat = 1;
        while (card_valid !== 1'b1 && lat < 60) begin
            cyc();
            lat++;
        end
        chk("deal_pulse_seen", 32'(card_valid === 1'b1), 1);
        cyc();
    endtask

    task automatic fresh_deck();
        new_deck = 1'b1;
        cyc();
        new_deck = 1'b0;
        got.delete();
    endtask

    function automatic int count_distinct();
        bit seen [52];
        int n = 0;
        foreach (got[k]) begin
            if (got[k] >= 0 && got[k] < 52 && !seen[got[k]]) begin
                seen[got[k]] = 1'b1;
                n++;
            end
        end
        return n;
    endfunction

    function automatic int missing_card();
        bit seen [52];
        foreach (got[k]) if (got[k] >= 0 && got[k] < 52) seen[got[k]] = 1'b1;
        for (int i = 0; i < 52; i++) if (!seen[i]) return i;
        return -1;
    endfunction

    initial begin
        int lat, n0, b;

        chk("pin_lfsr_step", 32'(lfsr_next(16'hACE1)), 32'h5670);
        chk("pin_rank_51", rank_of(51), 13);
        chk("pin_suit_51", suit_of(51), 3);
        chk("pin_card_13", rank_of(13) * 10 + suit_of(13), 11);
        chk("pin_value_Q", value_of(12), 10);
        chk("pin_value_A", value_of(1), 1);

        repeat (3) cyc();
        chk("rst_ready", 32'(ready), 1);
        chk("rst_valid", 32'(card_valid), 0);
        chk("rst_left", 32'(cards_left), 52);
        chk("rst_empty", 32'(deck_empty), 0);
        chk_en = 1'b1;
        resetb = 1'b1;
        cyc();

        got.delete();
        repeat (52) deal_one(lat);
        chk("full_pulses", got.size(), 52);
        chk("full_distinct", count_distinct(), 52);
        chk("full_left", 32'(cards_left), 0);
        chk("full_empty", 32'(deck_empty), 1);
        n0 = got.size();
        deal_req = 1'b1;
        cyc();
        deal_req = 1'b0;
        repeat (60) cyc();
        chk("empty_no_deal", got.size() - n0, 0);

        fresh_deck();
        repeat (51) deal_one(lat);
        n0 = missing_card();
        deal_one(lat);
        chk("wrap_latency_ok", 32'(lat >= 2 && lat <= 53), 1);
        chk("wrap_last_card", got[51], n0);
        chk("wrap_left", 32'(cards_left), 0);

        fresh_deck();
        deal_req = 1'b1;
        cyc();
        deal_req = 1'b0;
        new_deck = 1'b1;
        cyc();
        new_deck = 1'b0;
        chk("abort_ready", 32'(ready), 1);
        chk("abort_left", 32'(cards_left), 52);
        repeat (60) cyc();
        chk("abort_no_pulse", got.size(), 0);
        repeat (3) deal_one(lat);
        n0 = got.size();
        new_deck = 1'b1;
        deal_req = 1'b1;
        cyc();
        new_deck = 1'b0;
        deal_req = 1'b0;
        chk("clr_prio_left", 32'(cards_left), 52);
        chk("clr_prio_ready", 32'(ready), 1);
        repeat (60) cyc();
        chk("clr_prio_no_deal", got.size() - n0, 0);

        fresh_deck();
        min_sp = 1000;
        last_pulse = -1000;
        deal_req = 1'b1;
        b = 0;
        while (deck_empty !== 1'b1 && b < 3000) begin
            cyc();
            b++;
        end
        repeat (3) cyc();
        deal_req = 1'b0;
        chk("busy_pulses", got.size(), 52);
        chk("busy_distinct", count_distinct(), 52);
        chk("busy_spacing_ge3", 32'(min_sp >= 3), 1);
        chk("busy_left", 32'(cards_left), 0);

        fresh_deck();
        repeat (400) begin
            deal_req = 1'($urandom_range(0, 1));
            new_deck = ($urandom_range(0, 39) == 0);
            cyc();
        end
        deal_req = 1'b0;
        new_deck = 1'b0;
        repeat (60) cyc();

        fresh_deck();
        repeat (2) deal_one(lat);
        deal_req = 1'b1;
        cyc();
        deal_req = 1'b0;
        chk("pre_rst_busy", 32'(ready), 0);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 1);
        chk("arst_valid", 32'(card_valid), 0);
        chk("arst_left", 32'(cards_left), 52);
        chk("arst_empty", 32'(deck_empty), 0);
        chk("arst_rank", 32'(card_rank), 0);
        repeat (2) @(posedge clk);
        #3;
        resetb = 1'b1;
        repeat (5) cyc();
        deal_one(lat);
        chk("post_rst_left", 32'(cards_left), 51);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
